trng_sampler: RTL and testbench
===============================

Name: trng_sampler

Overview:
- Consumer end of the RS-latch entropy cell: samples its asynchronous raw bit, optionally whitens it with a von Neumann debiaser, and packs the result into bytes.
- Bytes leave over a valid/ready handshake toward the chip I/O pins.
- A repetition-count health test (RCT) on the raw samples flags a stuck or oscillation-locked source and blocks its output.

Parameters:
- DIV_W, 8, width of the sample-rate divider input.
- RCT_CUTOFF, 32, run length of identical raw samples that trips the health fail (legal range 2..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- ena  in  1  global enable; 0 freezes all state.
- raw_in  in  1  asynchronous raw bit from the entropy cell.
- div  in  DIV_W  sample period minus 1, in clk cycles.
- vn_en  in  1  1 = von Neumann debias, 0 = pass raw samples through.
- byte_ready  in  1  consumer accepts byte_out.
- fail_clr  in  1  clears health_fail and overflow.
- byte_out  out  8  assembled byte; first emitted bit is in bit 7.
- byte_valid  out  1  byte_out holds an unconsumed byte.
- health_fail  out  1  sticky RCT failure.
- overflow  out  1  sticky; a completed byte was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears synchronizer, divider, VN state, shift register, bit count, run counter and all outputs to 0.
- Synchronizer: 2-FF synchronizer on raw_in; its output is s. raw_in reaches s 2 cycles after it changes.
- Divider:
  - Counter runs 0..div.
  - strobe=1 in the cycle where count==div; the counter returns to 0 on the next edge.
  - div=0 gives a strobe every cycle.
  - div is sampled live; if count>div, the counter wraps to 0.
- ena=0: no state changes at all, including the divider and the handshake registers. Outputs hold.
- Sample: on a strobe, b = s.
- RCT:
  - On each strobe, if b==prev_b the run counter increments (saturating at RCT_CUTOFF); otherwise it reloads to 1. prev_b then takes b.
  - When the run reaches RCT_CUTOFF, health_fail is set on the same edge.
  - The first strobe after reset starts the run at 1.
- VN (vn_en=1): 2-state FSM.
  - VN_FIRST: store b, go to VN_SECOND.
  - VN_SECOND: if b differs from the stored bit, emit the stored bit; otherwise emit nothing. Return to VN_FIRST.
  - Any change of vn_en forces VN_FIRST.
- Pass-through (vn_en=0): every strobe emits b.
- Packer:
  - Each emitted bit shifts in at the LSB; the shift register shifts left, and the bit count increments.
  - On the 8th bit, the full byte is offered for load into byte_out on that same edge and the bit count returns to 0.
- Load rules for a completed byte:
  - byte_valid=0: load byte_out and set byte_valid=1. byte_valid appears the cycle after the strobe carrying bit 8.
  - byte_valid=1 and byte_ready=1 in the same cycle: load the new byte; byte_valid stays 1.
  - byte_valid=1 and byte_ready=0: drop the new byte, set overflow, keep byte_out.
- Handshake:
  - A transfer occurs when byte_valid and byte_ready are both 1. byte_valid clears next cycle unless a new byte loads.
  - byte_out is stable while byte_valid=1 and byte_ready=0.
- While health_fail=1:
  - No bits are emitted; the shift register and bit count are held at 0.
  - A byte already in byte_out remains deliverable.
  - Divider and RCT keep running.
- fail_clr:
  - Clears health_fail, overflow and the run counter; the next strobe restarts the run at 1.
  - If a fail-set and fail_clr occur in the same cycle, the set wins.
- Reset mid-byte or mid-pair discards partial state; no partial byte is ever output.

Decomposition:
- Package trng_pkg holds:
  - VN state enum {VN_FIRST, VN_SECOND};
  - default constants RCT_CUTOFF_DEF=32 and DIV_W_DEF=8.
- Sub-module trng_rct_monitor contains the run counter, prev_b and the sticky fail. Its ports are clk, rst_n, ena, strobe, b, fail_clr and fail.
- Synchronizer, divider, VN FSM and packer stay in trng_sampler.

Test Plan:
1. div=0, vn_en=0, byte_ready=1; drive raw_in with serial 1,0,1,1,0,0,1,0 (one per cycle) → byte_out=8'hB2 with byte_valid=1 for exactly 1 cycle, 11 cycles after the first bit; health_fail=0.
2. div=0, vn_en=1; drive sample pairs 10,01,00,10,11,01,10,01,10,01 → emitted bits 1,0,1,0,1,0,1,0 → byte_out=8'hAA. Pairs 00 and 11 produce no bits.
3. Backpressure, vn_en=0, byte_ready=0:
   - Stream 16 bits forming 8'h5A then 8'hC3 → byte_out stays 8'h5A and overflow=1.
   - Raise byte_ready → one transfer of 8'h5A, then byte_valid=0.
4. RCT, RCT_CUTOFF=32, vn_en=1, div=0, raw_in held 1:
   - health_fail=1 after the 32nd strobe; byte_valid never asserts.
   - Pulse fail_clr while the input toggles → health_fail=0, bytes resume.
5. div=3: strobe every 4th cycle, so 8 bits take 32 cycles. ena=0 for 10 cycles mid-byte → byte completes exactly 10 cycles later with identical content.
6. Reset mid-operation: after 5 bits shifted, rst_n=0 for 1 cycle → all outputs 0; the next byte_out is built from the 8 fresh bits only.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default constants for the TRNG sampler slice.
package trng_pkg;

  typedef enum logic {
    VN_FIRST,
    VN_SECOND
  } vn_state_e;

  localparam int unsigned RCT_CUTOFF_DEF = 32;
  localparam int unsigned DIV_W_DEF      = 8;

endpackage

// File: rtl/trng_sampler_if.sv
// Byte-stream valid/ready handshake from the sampler toward the I/O pins.
interface trng_sampler_if;

  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);

endinterface

// File: rtl/trng_rct_monitor.sv
// Repetition-count health test on raw samples; raises a sticky fail on a long run.
module trng_rct_monitor
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic strobe,
  input  logic b,
  input  logic fail_clr,
  output logic fail
);

  localparam logic [7:0] Cutoff = 8'(RCT_CUTOFF);

  logic [7:0] run_q;
  logic [7:0] run_inc;
  logic       prev_b_q;
  logic       fail_q;
  logic       set_fail;

  // A run count of 0 (after reset or clear) always restarts at 1.
  always_comb begin
    run_inc = 8'd1;
    if (b == prev_b_q) begin
      run_inc = (run_q == Cutoff) ? Cutoff : run_q + 8'd1;
    end
    set_fail = strobe && (run_inc == Cutoff);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= '0;
      prev_b_q <= 1'b0;
      fail_q   <= 1'b0;
    end else if (ena) begin
      if (strobe) prev_b_q <= b;
      if (set_fail)      run_q <= run_inc;
      else if (fail_clr) run_q <= '0;
      else if (strobe)   run_q <= run_inc;
      fail_q <= set_fail | (fail_q & ~fail_clr);
    end
  end

  assign fail = fail_q;

endmodule

// File: rtl/trng_sampler.sv
// Samples the asynchronous entropy bit, optionally von Neumann debiases it and
// packs bits MSB-first into bytes offered over a valid/ready handshake.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int unsigned DIV_W      = DIV_W_DEF,
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             raw_in,
  input  logic [DIV_W-1:0] div,
  input  logic             vn_en,
  input  logic             fail_clr,
  trng_sampler_if.master   bus,
  output logic             health_fail,
  output logic             overflow
);

  logic             sync1_q, s_q;
  logic [DIV_W-1:0] cnt_q;
  logic             strobe;
  vn_state_e        vn_q, vn_eff;
  logic             vn_bit_q, vn_en_q;
  logic [7:0]       sh_q, shifted;
  logic [2:0]       bcnt_q;
  logic [7:0]       byte_q;
  logic             valid_q, ovf_q, ovf_set;
  logic             fail;
  logic             emit, emit_bit, byte_done;

  assign strobe = (cnt_q == div);

  trng_rct_monitor #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .strobe  (strobe),
    .b       (s_q),
    .fail_clr(fail_clr),
    .fail    (fail)
  );

  // A toggle of vn_en restarts pairing as if the FSM were in VN_FIRST.
  always_comb begin
    vn_eff   = (vn_en != vn_en_q) ? VN_FIRST : vn_q;
    emit     = 1'b0;
    emit_bit = s_q;
    if (strobe && !fail) begin
      if (!vn_en) begin
        emit = 1'b1;
      end else if (vn_eff == VN_SECOND && s_q != vn_bit_q) begin
        emit     = 1'b1;
        emit_bit = vn_bit_q;
      end
    end
    shifted   = {sh_q[6:0], emit_bit};
    byte_done = emit && (bcnt_q == 3'd7);
    ovf_set   = byte_done && valid_q && !bus.byte_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      s_q      <= 1'b0;
      cnt_q    <= '0;
      vn_q     <= VN_FIRST;
      vn_bit_q <= 1'b0;
      vn_en_q  <= 1'b0;
      sh_q     <= '0;
      bcnt_q   <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (ena) begin
      sync1_q <= raw_in;
      s_q     <= sync1_q;
      cnt_q   <= (cnt_q >= div) ? '0 : cnt_q + DIV_W'(1);
      vn_en_q <= vn_en;

      if (strobe && vn_en) begin
        if (vn_eff == VN_FIRST) begin
          vn_bit_q <= s_q;
          vn_q     <= VN_SECOND;
        end else begin
          vn_q <= VN_FIRST;
        end
      end else if (vn_en != vn_en_q) begin
        vn_q <= VN_FIRST;
      end

      if (fail) begin
        sh_q   <= '0;
        bcnt_q <= '0;
      end else if (emit) begin
        sh_q   <= shifted;
        bcnt_q <= bcnt_q + 3'd1;
      end

      // A full byte is dropped only when the previous one is still unconsumed.
      if (byte_done && (!valid_q || bus.byte_ready)) begin
        byte_q  <= shifted;
        valid_q <= 1'b1;
      end else if (valid_q && bus.byte_ready) begin
        valid_q <= 1'b0;
      end

      ovf_q <= ovf_set | (ovf_q & ~fail_clr);
    end
  end

  assign bus.byte_out   = byte_q;
  assign bus.byte_valid = valid_q;
  assign health_fail    = fail;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Directed bench for trng_sampler: table-driven byte vectors plus hand-written corner sequences.
module tb_trng_sampler;

  logic       clk = 1'b0;
  logic       rst_n, ena, raw_in, vn_en, fail_clr, health_fail, overflow;
  logic [7:0] div;

  always #5 clk = ~clk;

  trng_sampler_if bus ();

  trng_sampler #(
    .DIV_W     (8),
    .RCT_CUTOFF(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .raw_in     (raw_in),
    .div        (div),
    .vn_en      (vn_en),
    .fail_clr   (fail_clr),
    .bus        (bus),
    .health_fail(health_fail),
    .overflow   (overflow)
  );

  typedef struct {
    logic        vn;
    logic [31:0] smp;
    int          n;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         at;
  } xfer_t;

  vec_t       tbl[9];
  xfer_t      got[$];
  logic [7:0] expq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         vcnt = 0;
  logic       valid_seen = 1'b0;
  int         t0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded half a cycle before the edge on which they occur.
  always @(negedge clk) begin
    if (rst_n && ena && bus.byte_valid && bus.byte_ready) got.push_back('{bus.byte_out, cyc + 1});
    if (rst_n && bus.byte_valid) begin
      valid_seen = 1'b1;
      vcnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic v);
    rst_n    = 1'b0;
    ena      = 1'b1;
    vn_en    = v;
    raw_in   = 1'b0;
    fail_clr = 1'b0;
    tick(1);
    rst_n = 1'b1;
    got.delete();
    valid_seen = 1'b0;
    vcnt = 0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      raw_in = v[i];
      tick(1);
    end
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 60) begin
      tick(1);
      k++;
    end
    check(name, 32'(got.size()), 32'(n));
  endtask

  task automatic compare_queue(input string name);
    for (int k = 0; k < expq.size(); k++) begin
      if (k < got.size()) check(name, 32'(got[k].data), 32'(expq[k]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'hB2, 8, 8'hB2};
    tbl[1] = '{1'b0, 32'h5A, 8, 8'h5A};
    tbl[2] = '{1'b0, 32'hC3, 8, 8'hC3};
    tbl[3] = '{1'b0, 32'hFF, 8, 8'hFF};
    tbl[4] = '{1'b0, 32'h00, 8, 8'h00};
    tbl[5] = '{1'b0, 32'h81, 8, 8'h81};
    tbl[6] = '{1'b1, 32'b10_01_00_10_11_01_10_01_10_01, 20, 8'hAA};
    tbl[7] = '{1'b1, 32'b01_01_01_01_10_10_10_10, 16, 8'h0F};
    tbl[8] = '{1'b1, 32'b00_10_11_10_01_01_00_10_10_01_01, 22, 8'hCC};

    div = 8'd0;
    bus.byte_ready = 1'b1;
    do_reset(1'b0);
    check("reset_byte_out", 32'(bus.byte_out), 32'h0);
    check("reset_byte_valid", 32'(bus.byte_valid), 32'h0);
    check("reset_health_fail", 32'(health_fail), 32'h0);
    check("reset_overflow", 32'(overflow), 32'h0);

    // Pass-through vectors back to back; the 2 synchronizer warm-up samples
    // plus 6 driven zeros form a leading 0x00 byte that aligns the stream.
    send(32'h0, 6);
    t0 = cyc;
    expq.delete();
    expq.push_back(8'h00);
    for (int i = 0; i < 9; i++) begin
      if (!tbl[i].vn) begin
        send(tbl[i].smp, tbl[i].n);
        expq.push_back(tbl[i].exp);
      end
    end
    wait_bytes(expq.size(), "pass_count");
    compare_queue("pass_byte");
    if (got.size() > 1) check("first_byte_latency", 32'(got[1].at), 32'(t0 + 11));
    check("valid_one_cycle_each", 32'(vcnt), 32'(expq.size()));
    check("pass_health_fail", 32'(health_fail), 32'h0);

    // Von Neumann vectors; warm-up and prime samples pair into 00 and emit nothing.
    do_reset(1'b1);
    send(32'h0, 6);
    expq.delete();
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].vn) begin
        send(tbl[i].smp, tbl[i].n);
        expq.push_back(tbl[i].exp);
      end
    end
    wait_bytes(expq.size(), "vn_count");
    compare_queue("vn_byte");

    // Backpressure: 0x5A is held while 0xC3 is dropped.
    do_reset(1'b0);
    send(32'h0, 6);
    send(32'b010, 3);
    bus.byte_ready = 1'b0;
    send(32'b11010, 5);
    send(32'hC3, 8);
    tick(1);
    check("bp_overflow_before", 32'(overflow), 32'h0);
    check("bp_valid_held", 32'(bus.byte_valid), 32'h1);
    tick(1);
    check("bp_overflow_set", 32'(overflow), 32'h1);
    check("bp_byte_stable", 32'(bus.byte_out), 32'h5A);
    bus.byte_ready = 1'b1;
    tick(1);
    check("bp_valid_cleared", 32'(bus.byte_valid), 32'h0);
    check("bp_xfer_count", 32'(got.size()), 32'd2);
    if (got.size() > 1) check("bp_xfer_byte", 32'(got[1].data), 32'h5A);
    fail_clr = 1'b1;
    tick(1);
    fail_clr = 1'b0;
    check("bp_overflow_cleared", 32'(overflow), 32'h0);

    // RCT: raw held high trips on the 32nd identical sample, then recovers.
    do_reset(1'b1);
    raw_in = 1'b1;
    tick(33);
    check("rct_before_trip", 32'(health_fail), 32'h0);
    tick(1);
    check("rct_trip", 32'(health_fail), 32'h1);
    for (int i = 0; i < 40; i++) begin
      raw_in   = (i % 2 == 0);
      fail_clr = (i == 3);
      tick(1);
      if (i == 2) check("rct_no_valid_while_stuck", 32'(valid_seen), 32'h0);
      if (i == 3) check("rct_cleared", 32'(health_fail), 32'h0);
    end
    fail_clr = 1'b0;
    check("rct_resume_count", 32'(got.size() >= 1), 32'h1);
    if (got.size() > 0) check("rct_resume_byte", 32'(got[0].data), 32'hFF);
    check("rct_stays_clear", 32'(health_fail), 32'h0);

    // div=3 with a 10-cycle ena freeze inside the byte.
    div = 8'd3;
    bus.byte_ready = 1'b0;
    do_reset(1'b0);
    for (int i = 7; i >= 4; i--) begin
      raw_in = 8'h96 >> i;
      tick(4);
    end
    ena = 1'b0;
    raw_in = 1'b0;
    tick(10);
    check("freeze_valid_held", 32'(bus.byte_valid), 32'h0);
    ena = 1'b1;
    tick(4);
    raw_in = 1'b1;
    tick(4);
    raw_in = 1'b1;
    tick(4);
    raw_in = 1'b0;
    tick(3);
    check("div_valid_not_early", 32'(bus.byte_valid), 32'h0);
    tick(1);
    check("div_valid_on_time", 32'(bus.byte_valid), 32'h1);
    check("div_byte", 32'(bus.byte_out), 32'h96);

    // Reset mid-byte discards the 5 partially shifted ones.
    div = 8'd0;
    bus.byte_ready = 1'b1;
    do_reset(1'b0);
    send(32'h0, 6);
    send(32'hE7, 8);
    send(32'b11111, 5);
    tick(3);
    check("mid_pre_count", 32'(got.size()), 32'd2);
    do_reset(1'b0);
    check("mid_reset_byte_out", 32'(bus.byte_out), 32'h0);
    check("mid_reset_valid", 32'(bus.byte_valid), 32'h0);
    check("mid_reset_overflow", 32'(overflow), 32'h0);
    check("mid_reset_health", 32'(health_fail), 32'h0);
    send(32'h0, 6);
    send(32'h3C, 8);
    expq.delete();
    expq.push_back(8'h00);
    expq.push_back(8'h3C);
    wait_bytes(2, "mid_count");
    compare_queue("mid_byte");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
